// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified IF/DM memory arbiter: FSM states and
// grant encodings (grant values double as the address-mux select).
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_BUSY = 2'd1,
    S_DM_BUSY = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_mux.sv
// Parameterized 2x1 mux: sel=0 passes d0, sel=1 passes d1.
module mux #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and data
// memory stages, with alternating priority under contention and a timeout abort.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          addr_sel,
  output logic          err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          if_valid_q, if_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          dm_valid_q, dm_valid_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          addr_sel_q, addr_sel_d;
  logic          err_q, err_d;

  logic          if_ok, gnt_dm, gnt_any, sel_nxt;
  logic [AW-1:0] addr_mux;

  // A flushed fetch is not eligible; DM yields only when IF wants the slot
  // and DM held the last completed grant.
  always_comb begin
    if_ok   = if_req & ~if_flush;
    gnt_dm  = dm_req & ~(if_ok & (last_grant_q == GNT_DM));
    gnt_any = dm_req | if_ok;
    sel_nxt = (state_q == S_IDLE) ? gnt_dm : addr_sel_q;
  end

  mux #(.WIDTH(AW)) u_addr_mux (
    .sel (sel_nxt),
    .d0  (if_addr),
    .d1  (dm_addr),
    .y   (addr_mux)
  );

  logic          is_if, drop_now, finish, timed_out;
  logic [DW-1:0] fin_data;

  always_comb begin
    // NOTE: every _d takes its hold value first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    cnt_d        = cnt_q;
    if_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_valid_d   = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    addr_sel_d   = addr_sel_q;
    err_d        = err_q;
    is_if        = (state_q == S_IF_BUSY);
    drop_now     = drop_q | (is_if & if_flush);
    timed_out    = ~mem_ack & (cnt_q >= CNT_LAST);
    finish       = mem_ack | timed_out;
    fin_data     = mem_ack ? mem_rdata : '0;

    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          state_d     = gnt_dm ? S_DM_BUSY : S_IF_BUSY;
          addr_sel_d  = gnt_dm;
          mem_addr_d  = addr_mux;
          mem_we_d    = gnt_dm & dm_we;
          mem_wdata_d = gnt_dm ? dm_wdata : '0;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          drop_d      = 1'b0;
        end
      end
      S_IF_BUSY, S_DM_BUSY: begin
        drop_d = drop_now;
        if (finish) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          if (is_if) begin
            if (!drop_now) begin
              if_valid_d = 1'b1;
              if_rdata_d = fin_data;
            end
          end else begin
            dm_valid_d = 1'b1;
            // Stores leave load data alone unless the access aborted.
            if (!mem_we_q || timed_out) dm_rdata_d = fin_data;
          end
          if (mem_ack) last_grant_d = is_if ? GNT_IF : GNT_DM;
          if (timed_out) begin
            err_d = 1'b1;
            cnt_d = CNT_MAX;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_IF;
      drop_q       <= 1'b0;
      cnt_q        <= '0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_valid_q   <= 1'b0;
      dm_rdata_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      addr_sel_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
      cnt_q        <= cnt_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      dm_valid_q   <= dm_valid_d;
      dm_rdata_q   <= dm_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      addr_sel_q   <= addr_sel_d;
      err_q        <= err_d;
    end
  end

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign addr_sel  = addr_sel_q;
  assign err       = err_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a transaction-level model checked
// every cycle, plus literal expectations for each scenario.
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush;
  logic [AW-1:0] if_addr;
  logic          if_valid, if_stall;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_valid, dm_stall;
  logic [DW-1:0] dm_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          addr_sel, err;

  int n_checks = 0;
  int n_fail   = 0;

  unified_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .addr_sel(addr_sel), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: owner 0 = none, 1 = IF, 2 = DM.
  // age counts cycles since mem_req rose; done marks the completion cycle.
  bit            m_on = 1'b0;
  int            m_owner, m_age;
  bit            m_done, m_drop, m_last_dm;
  logic          e_mem_req, e_mem_we, e_addr_sel, e_err;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_if_rdata, e_dm_rdata;
  logic          e_if_valid, e_dm_valid;

  task automatic m_finish(input logic [DW-1:0] data, input bit aborted);
    e_mem_req = 1'b0;
    m_done    = 1'b1;
    if (!aborted) m_last_dm = (m_owner == 2);
    if (aborted) e_err = 1'b1;
    if (m_owner == 1) begin
      if (!m_drop) begin
        e_if_valid = 1'b1;
        e_if_rdata = data;
      end
    end else begin
      e_dm_valid = 1'b1;
      if (!e_mem_we || aborted) e_dm_rdata = data;
    end
  endtask

  task automatic model_step();
    bit if_ok;
    if (rst) begin
      m_on = 1'b1; m_owner = 0; m_age = 0; m_done = 0; m_drop = 0; m_last_dm = 0;
      e_mem_req = 0; e_mem_we = 0; e_addr_sel = 0; e_err = 0;
      e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
      e_if_valid = 0; e_dm_valid = 0;
    end else if (m_on) begin
      e_if_valid = 1'b0;
      e_dm_valid = 1'b0;
      if (m_done) begin
        m_done  = 1'b0;
        m_owner = 0;
      end else if (m_owner == 0) begin
        if_ok = if_req && !if_flush;
        if (dm_req && !(if_ok && m_last_dm)) begin
          m_owner = 2; e_addr_sel = 1'b1; e_mem_addr = dm_addr;
          e_mem_we = dm_we; e_mem_wdata = dm_wdata;
        end else if (if_ok) begin
          m_owner = 1; e_addr_sel = 1'b0; e_mem_addr = if_addr;
          e_mem_we = 1'b0;
        end
        if (m_owner != 0) begin
          e_mem_req = 1'b1; m_age = 0; m_drop = 1'b0;
        end
      end else begin
        if (m_owner == 1 && if_flush) m_drop = 1'b1;
        if (mem_ack) m_finish(mem_rdata, 1'b0);
        else begin
          m_age++;
          if (m_age == TIMEOUT) m_finish('0, 1'b1);
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (m_on) begin
      check("cyc_mem_req", mem_req, e_mem_req);
      check("cyc_if_valid", if_valid, e_if_valid);
      check("cyc_dm_valid", dm_valid, e_dm_valid);
      check("cyc_if_rdata", if_rdata, e_if_rdata);
      check("cyc_dm_rdata", dm_rdata, e_dm_rdata);
      check("cyc_err", err, e_err);
      check("cyc_if_stall", if_stall, if_req & ~e_if_valid);
      check("cyc_dm_stall", dm_stall, dm_req & ~e_dm_valid);
      if (e_mem_req) begin
        check("cyc_mem_addr", mem_addr, e_mem_addr);
        check("cyc_mem_we", mem_we, e_mem_we);
        check("cyc_addr_sel", addr_sel, e_addr_sel);
        if (e_mem_we) check("cyc_mem_wdata", mem_wdata, e_mem_wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [0:3] alt_sel;
  int n;

  initial begin
    rst = 1'b1; if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_ack = 0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_mem_req", mem_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_err", err, 0);
    check("rst_if_rdata", if_rdata, 0);

    // Flush in IDLE blocks the fetch grant for that cycle.
    if_req = 1; if_addr = 32'h0040_0000; if_flush = 1;
    tick();
    if_flush = 0;
    check("flush_idle_no_grant", mem_req, 0);

    // IF-only load, ack on the second busy cycle.
    tick();
    check("if_mem_req", mem_req, 1);
    check("if_mem_addr", mem_addr, 32'h0040_0000);
    check("if_mem_we", mem_we, 0);
    check("if_addr_sel", addr_sel, 0);
    tick();
    mem_ack = 1; mem_rdata = 32'h2008_0005;
    tick();
    mem_ack = 0; mem_rdata = '0;
    check("if_valid_pulse", if_valid, 1);
    check("if_rdata_val", if_rdata, 32'h2008_0005);
    if_req = 0;
    tick();
    check("if_valid_one_cycle", if_valid, 0);

    // Contention from reset: DM, IF, DM, IF.
    rst = 1; tick(); rst = 0;
    if_req = 1; if_addr = 32'h0040_0004;
    dm_req = 1; dm_we = 0; dm_addr = 32'h1001_0000;
    alt_sel = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("alt_mem_req", mem_req, 1);
      check("alt_addr_sel", addr_sel, alt_sel[g]);
      mem_ack = 1; mem_rdata = 32'hA000_0000 + 32'(g);
      tick();
      mem_ack = 0;
      check("alt_valid", alt_sel[g] ? dm_valid : if_valid, 1);
      tick();
    end
    if_req = 0; dm_req = 0;

    // DM store: load data untouched.
    dm_req = 1; dm_we = 1; dm_addr = 32'h1001_0004; dm_wdata = 32'hDEAD_BEEF;
    tick();
    check("st_mem_we", mem_we, 1);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_mem_addr", mem_addr, 32'h1001_0004);
    check("st_addr_sel", addr_sel, 1);
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 0;
    check("st_dm_valid", dm_valid, 1);
    check("st_dm_rdata_kept", dm_rdata, 32'hA000_0002);
    dm_req = 0; dm_we = 0;
    tick();

    // Flush one cycle into IF_BUSY: completion is swallowed.
    if_req = 1; if_addr = 32'h0040_0100;
    tick();
    if_flush = 1;
    tick();
    if_flush = 0;
    tick();
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 0;
    check("fl_no_valid", if_valid, 0);
    check("fl_rdata_kept", if_rdata, 32'hA000_0003);
    if_addr = 32'h0040_0200;
    tick();
    tick();
    check("fl_regrant_req", mem_req, 1);
    check("fl_regrant_addr", mem_addr, 32'h0040_0200);
    mem_ack = 1; mem_rdata = 32'h8C08_0000;
    tick();
    mem_ack = 0;
    check("fl_regrant_valid", if_valid, 1);
    check("fl_regrant_rdata", if_rdata, 32'h8C08_0000);
    if_req = 0;
    tick();

    // Timeout: abort TIMEOUT cycles after mem_req rises.
    if_req = 1; if_addr = 32'h0040_0300;
    tick();
    check("to_mem_req", mem_req, 1);
    n = 0;
    while (!if_valid && n < 20) begin
      tick();
      n++;
    end
    check("to_cycles", n, 8);
    check("to_valid", if_valid, 1);
    check("to_rdata_zero", if_rdata, 0);
    check("to_err", err, 1);
    if_req = 0;
    repeat (3) tick();
    check("to_err_sticky", err, 1);

    // Reset during DM_BUSY, late ack afterwards is ignored.
    dm_req = 1; dm_we = 0; dm_addr = 32'h1001_0008;
    tick();
    check("rb_mem_req", mem_req, 1);
    rst = 1;
    tick();
    rst = 0; dm_req = 0;
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 0;
    check("rb_mem_req_low", mem_req, 0);
    check("rb_no_valid", dm_valid, 0);
    check("rb_dm_rdata", dm_rdata, 0);
    check("rb_err_clr", err, 0);
    check("rb_addr_sel", addr_sel, 0);
    check("rb_if_rdata", if_rdata, 0);
    tick();
    check("rb_idle_req", mem_req, 0);
    check("rb_idle_valid", dm_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
